dmem_ctrl: RTL
==============

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16: max cycles in REQ without mem_ack before abort; legal range 1..255.
REQ-002 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 Port rst, input, 1: asynchronous, active-low reset.
REQ-004 Port cpu_ren, input, 1: CPU load request, level, held while cpu_stall=1.
REQ-005 Port cpu_wen, input, 1: CPU store request, level, held while cpu_stall=1.
REQ-006 Port cpu_addr, input, 32: byte address from the CPU ALU result.
REQ-007 Port cpu_wdata, input, 32: store data from register-file read port 2.
REQ-008 Port cpu_rdata, output, 32: load data to the register-file write mux; registered.
REQ-009 Port cpu_stall, output, 1: freezes the CPU PC and register writes while high.
REQ-010 Port cpu_err, output, 1: one-cycle error pulse, coincident with completion.
REQ-011 Port mem_req, output, 1: request to the memory side; registered.
REQ-012 Port mem_we, output, 1: 1 = write, 0 = read; registered.
REQ-013 Port mem_addr, output, 32: word-aligned address {addr[31:2],2'b00}; registered.
REQ-014 Port mem_wdata, output, 32: write data; registered.
REQ-015 Port mem_ack, input, 1: memory completion, single-cycle pulse.
REQ-016 Port mem_rdata, input, 32: read data, valid only in the cycle mem_ack=1.

Function
REQ-017 The FSM SHALL have three states: IDLE, REQ and DONE.
REQ-018 In IDLE with cpu_ren|cpu_wen=1, the block SHALL latch the address, data and direction into the mem_* registers and enter REQ on the next edge.
REQ-019 If cpu_wen and cpu_ren are both 1, the access SHALL be a write.
REQ-020 cpu_stall SHALL be combinational: 1 in IDLE with a request pending and 1 throughout REQ; 0 in DONE and in an idle IDLE.
REQ-021 In REQ, mem_req SHALL stay 1 and mem_addr, mem_we and mem_wdata SHALL stay constant until mem_ack or timeout.
REQ-022 When mem_ack=1 in REQ, the block SHALL clear mem_req, enter DONE and load cpu_rdata from mem_rdata, for reads only.
REQ-023 A write SHALL leave cpu_rdata unchanged.
REQ-024 Latency: request in IDLE at cycle 0 → mem_req=1 at cycle 1; mem_ack at cycle k → DONE with cpu_stall=0 at cycle k+1.
REQ-025 A wait counter SHALL clear on entry to REQ and increment each REQ cycle without mem_ack.
REQ-026 When the counter reaches TIMEOUT-1 without mem_ack, the block SHALL clear mem_req, enter DONE, pulse cpu_err and load cpu_rdata with 32'h0 for reads.
REQ-027 If mem_ack and the timeout condition occur in the same cycle, mem_ack SHALL take priority and cpu_err SHALL stay 0.
REQ-028 DONE SHALL last exactly one cycle and then return to IDLE unconditionally; a request present in DONE SHALL NOT be accepted until IDLE.
REQ-029 mem_ack in IDLE or DONE SHALL be ignored, with no state, data or error change.

Reset
REQ-030 rst=0 SHALL force, immediately and without clk: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rdata=0, cpu_err=0 and counter=0.
REQ-031 Reset during REQ SHALL abandon the access; a mem_ack arriving after reset release SHALL be ignored per REQ-029.

Configuration
REQ-032 Macro DMEM_ALIGN_CHECK_EN defined: a request in IDLE with cpu_addr[1:0]!=0 SHALL go directly to DONE with no mem_req, pulse cpu_err and leave cpu_rdata unchanged.
REQ-033 Macro DMEM_ALIGN_CHECK_EN undefined: cpu_addr[1:0] SHALL be ignored and the access proceeds word-aligned with no error.

Verification
REQ-034 Read: cpu_ren=1, addr=0x100; mem_ack at cycle 3 with rdata=0xCAFEF00D → mem_addr=0x100, mem_we=0, cpu_rdata=0xCAFEF00D, cpu_stall falls at cycle 4, cpu_err=0.
REQ-035 Write: cpu_wen=1, addr=0x204, wdata=0x12345678; mem_ack at cycle 1 → mem_we=1, mem_wdata=0x12345678, cpu_rdata unchanged, DONE at cycle 2.
REQ-036 Timeout: TIMEOUT=4, read with no mem_ack → mem_req low after 4 REQ cycles, cpu_err=1 for 1 cycle, cpu_rdata=0.
REQ-037 Race: TIMEOUT=4, mem_ack in the 4th REQ cycle with rdata=0x55 → cpu_rdata=0x55, cpu_err=0.
REQ-038 Reset: rst=0 mid-REQ → mem_req=0 with no clock edge; after release, a stray mem_ack leaves the FSM in IDLE.
REQ-039 Alignment: read addr=0x102 → with DMEM_ALIGN_CHECK_EN: no mem_req, cpu_err pulse; without it: mem_addr=0x100, normal completion.

Source files
------------

// File: rtl/dmem_ctrl_if.sv
// CPU-side and memory-side signal bundle for the data-memory controller.
// slave = the controller itself, master = the CPU/memory environment driving it.
interface dmem_ctrl_if;
  logic        cpu_ren;
  logic        cpu_wen;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        cpu_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  cpu_ren, cpu_wen, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
    output cpu_rdata, cpu_stall, cpu_err, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_ren, cpu_wen, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
    input  cpu_rdata, cpu_stall, cpu_err, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory controller: one outstanding CPU load/store per IDLE->REQ->DONE pass, with timeout.
// Define DMEM_ALIGN_CHECK_EN to reject misaligned addresses with an error instead of aligning them.
module dmem_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input logic        clk,
  input logic        rst,
  dmem_ctrl_if.slave bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;
  logic        cpu_err_q, cpu_err_d;

  logic req_valid;
  logic misaligned;
  logic timed_out;

  assign req_valid = bus.cpu_ren | bus.cpu_wen;
  assign timed_out = (cnt_q == TimeoutLast);

`ifdef DMEM_ALIGN_CHECK_EN
  assign misaligned = |bus.cpu_addr[1:0];
`else
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^bus.cpu_addr[1:0];
  assign misaligned       = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    cpu_err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (misaligned) begin
            state_d   = StDone;
            cpu_err_d = 1'b1;
          end else begin
            state_d     = StReq;
            mem_req_d   = 1'b1;
            // A simultaneous load+store request is treated as a store.
            mem_we_d    = bus.cpu_wen;
            mem_addr_d  = {bus.cpu_addr[31:2], 2'b00};
            mem_wdata_d = bus.cpu_wdata;
            cnt_d       = 8'd0;
          end
        end
      end
      StReq: begin
        // mem_ack wins over a timeout landing in the same cycle.
        if (bus.mem_ack) begin
          state_d   = StDone;
          mem_req_d = 1'b0;
          cnt_d     = 8'd0;
          if (!mem_we_q) cpu_rdata_d = bus.mem_rdata;
        end else if (timed_out) begin
          state_d   = StDone;
          mem_req_d = 1'b0;
          cnt_d     = 8'd0;
          cpu_err_d = 1'b1;
          if (!mem_we_q) cpu_rdata_d = 32'h0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      cpu_rdata_q <= 32'h0;
      cpu_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_err_q   <= cpu_err_d;
    end
  end

  assign bus.cpu_stall = ((state_q == StIdle) && req_valid) || (state_q == StReq);
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.cpu_err   = cpu_err_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule
